// File: rtl/dir_bus_pkg.sv
// Shared types for the directed-bus packet reader: FSM state encoding and
// the beat record stored in the FIFO.
package dir_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    DISCARD = 2'd2
  } state_e;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } beat_t;

endpackage

// File: rtl/dir_bus_fifo.sv
// First-word-fall-through beat FIFO. The read port is forced to zero while
// empty so the downstream side never sees stale storage.
module dir_bus_fifo
  import dir_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  beat_t                      wdata_i,
  input  logic                       pop_i,
  output beat_t                      rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  beat_t           mem_q [DEPTH];
  logic [AW-1:0]   wrPtr_q;
  logic [AW-1:0]   rdPtr_q;
  logic [LW-1:0]   level_q;
  logic            doPush;
  logic            doPop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign doPush  = push_i & ~full_o;
  assign doPop   = pop_i & ~empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rdPtr_q];

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= wdata_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/dir_bus_reader.sv
// Packet reader: buffers upstream beats into a FIFO, truncates packets longer
// than MAX_LEN (forcing last on the final kept beat) and drops the tail.
module dir_bus_reader
  import dir_bus_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAX_LEN = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 s_data,
  input  logic                       s_valid,
  input  logic                       s_last,
  output logic                       s_ready,
  output logic [7:0]                 m_data,
  output logic                       m_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  input  logic                       err_clr,
  output logic                       len_err,
  output logic [15:0]                pkt_cnt,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int CW = $clog2(MAX_LEN);

  state_e        state_q, state_d;
  logic [CW-1:0] beatCnt_q, beatCnt_d;
  logic          lenErr_q, lenErr_d;
  logic [15:0]   pktCnt_q, pktCnt_d;
  logic          accept;
  logic          atMax;
  logic          push;
  logic          pop;
  logic          setErr;
  logic          fifoFull;
  logic          fifoEmpty;
  beat_t         wrBeat;
  beat_t         rdBeat;

  dir_bus_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (wrBeat),
    .pop_i   (pop),
    .rdata_o (rdBeat),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .level_o (level)
  );

  // A full FIFO stays not-ready even if it is being drained this cycle.
  assign s_ready = ~rst & ((state_q == DISCARD) | ~fifoFull);
  assign accept  = s_valid & s_ready;
  assign atMax   = (beatCnt_q == CW'(MAX_LEN - 1));
  assign m_valid = ~fifoEmpty;
  assign pop     = m_valid & m_ready;
  assign m_data  = rdBeat.data;
  assign m_last  = rdBeat.last;
  assign len_err = lenErr_q;
  assign pkt_cnt = pktCnt_q;

  always_comb begin
    state_d     = state_q;
    beatCnt_d   = beatCnt_q;
    push        = 1'b0;
    setErr      = 1'b0;
    wrBeat.last = s_last;
    wrBeat.data = s_data;
    case (state_q)
      IDLE, RECV: begin
        if (accept) begin
          push = 1'b1;
          if (atMax && !s_last) begin
            wrBeat.last = 1'b1;
            setErr      = 1'b1;
            state_d     = DISCARD;
            beatCnt_d   = '0;
          end else if (s_last) begin
            state_d   = IDLE;
            beatCnt_d = '0;
          end else begin
            state_d   = RECV;
            beatCnt_d = beatCnt_q + 1'b1;
          end
        end
      end
      DISCARD: begin
        if (accept && s_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pktCnt_d = pktCnt_q;
    if (push && wrBeat.last) pktCnt_d = pktCnt_q + 16'd1;
    lenErr_d = lenErr_q;
    if (setErr)       lenErr_d = 1'b1;
    else if (err_clr) lenErr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      beatCnt_q <= '0;
      lenErr_q  <= 1'b0;
      pktCnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      beatCnt_q <= beatCnt_d;
      lenErr_q  <= lenErr_d;
      pktCnt_q  <= pktCnt_d;
    end
  end

endmodule

// File: tb/tb_dir_bus_reader.sv
// Directed bench for dir_bus_reader: streaming, backpressure, truncation,
// error stickiness, reset mid-packet and packet counter wrap.
module tb_dir_bus_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_last;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        err_clr = 1'b0;
  logic        len_err;
  logic [15:0] pkt_cnt;
  logic [2:0]  level;

  int errors = 0;
  int checks = 0;

  dir_bus_reader #(.DEPTH(4), .MAX_LEN(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .err_clr (err_clr),
    .len_err (len_err),
    .pkt_cnt (pkt_cnt),
    .level   (level)
  );

  always #5 clk = ~clk;

  task test_reset;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_ready actual=%0b expected=0", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid actual=%0b expected=0", m_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL reset_level actual=%0d expected=0", level); end
    checks++; if (pkt_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_pkt_cnt actual=%0d expected=0", pkt_cnt); end
    checks++; if (len_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_len_err actual=%0b expected=0", len_err); end
    checks++; if ({m_last, m_data} !== 9'd0) begin errors++; $display("[TB] FAIL reset_m_data actual=%h expected=000", {m_last, m_data}); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_s_ready actual=%0b expected=1", s_ready); end
  endtask

  task test_basic;
    logic [7:0] d [3];
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = d[i]; s_last = (i == 2);
      @(posedge clk); #1;
      checks++;
      if (m_valid !== 1'b1 || m_data !== d[i] || m_last !== (i == 2)) begin
        errors++; $display("[TB] FAIL basic_beat%0d actual=%0b/%h/%0b expected=1/%h/%0b", i, m_valid, m_data, m_last, d[i], (i == 2));
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    @(posedge clk); #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_drain actual=%0b expected=0", m_valid); end
    checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("[TB] FAIL basic_pkt_cnt actual=%0d expected=1", pkt_cnt); end
  endtask

  task test_backpressure;
    logic [7:0] a [6];
    for (int i = 0; i < 6; i++) a[i] = 8'hA0 + 8'(i);
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = a[i]; s_last = 1'b0;
      checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready%0d actual=%0b expected=1", i, s_ready); end
      @(posedge clk); #1;
    end
    s_data = a[4];
    checks++; if (level !== 3'd4) begin errors++; $display("[TB] FAIL bp_level_full actual=%0d expected=4", level); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_full actual=%0b expected=0", s_ready); end
    @(posedge clk); #1;
    checks++; if (level !== 3'd4) begin errors++; $display("[TB] FAIL bp_level_hold actual=%0d expected=4", level); end
    checks++; if (m_data !== a[0]) begin errors++; $display("[TB] FAIL bp_head_stable actual=%h expected=%h", m_data, a[0]); end
    m_ready = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_same_cycle_pop actual=%0b expected=0", s_ready); end
    @(posedge clk); #1;
    checks++; if (level !== 3'd3 || m_data !== a[1]) begin errors++; $display("[TB] FAIL bp_first_pop actual=%0d/%h expected=3/%h", level, m_data, a[1]); end
    @(posedge clk); #1;
    checks++; if (level !== 3'd3 || m_data !== a[2]) begin errors++; $display("[TB] FAIL bp_accept4 actual=%0d/%h expected=3/%h", level, m_data, a[2]); end
    s_data = a[5]; s_last = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (m_data !== a[3] || m_last !== 1'b0) begin errors++; $display("[TB] FAIL bp_out3 actual=%h/%0b expected=%h/0", m_data, m_last, a[3]); end
    @(posedge clk); #1;
    checks++; if (m_data !== a[4] || m_last !== 1'b0) begin errors++; $display("[TB] FAIL bp_out4 actual=%h/%0b expected=%h/0", m_data, m_last, a[4]); end
    @(posedge clk); #1;
    checks++; if (m_data !== a[5] || m_last !== 1'b1 || level !== 3'd1) begin errors++; $display("[TB] FAIL bp_out5 actual=%h/%0b/%0d expected=%h/1/1", m_data, m_last, level, a[5]); end
    @(posedge clk); #1;
    checks++; if (m_valid !== 1'b0 || pkt_cnt !== 16'd2) begin errors++; $display("[TB] FAIL bp_end actual=%0b/%0d expected=0/2", m_valid, pkt_cnt); end
  endtask

  task test_overflow;
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1; s_data = 8'(i + 1); s_last = (i == 19);
      if (i == 16) begin
        checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL ovf_discard_ready actual=%0b expected=1", s_ready); end
      end
      @(posedge clk); #1;
      checks++;
      if (i < 16) begin
        if (m_valid !== 1'b1 || m_data !== 8'(i + 1) || m_last !== (i == 15)) begin
          errors++; $display("[TB] FAIL ovf_beat%0d actual=%0b/%h/%0b expected=1/%h/%0b", i, m_valid, m_data, m_last, 8'(i + 1), (i == 15));
        end
      end else if (m_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL ovf_dropped%0d actual=%0b expected=0", i, m_valid);
      end
      if (i == 15) begin
        checks++; if (len_err !== 1'b1) begin errors++; $display("[TB] FAIL ovf_len_err_set actual=%0b expected=1", len_err); end
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (pkt_cnt !== 16'd3) begin errors++; $display("[TB] FAIL ovf_pkt_cnt actual=%0d expected=3", pkt_cnt); end
    checks++; if (len_err !== 1'b1) begin errors++; $display("[TB] FAIL ovf_len_err_sticky actual=%0b expected=1", len_err); end
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    checks++; if (len_err !== 1'b0) begin errors++; $display("[TB] FAIL ovf_err_clr actual=%0b expected=0", len_err); end
  endtask

  task test_exact_and_clear_race;
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_data = 8'h30 + 8'(i); s_last = (i == 15);
      @(posedge clk); #1;
      checks++;
      if (m_valid !== 1'b1 || m_data !== 8'h30 + 8'(i) || m_last !== (i == 15)) begin
        errors++; $display("[TB] FAIL exact_beat%0d actual=%0b/%h/%0b expected=1/%h/%0b", i, m_valid, m_data, m_last, 8'h30 + 8'(i), (i == 15));
      end
    end
    checks++; if (len_err !== 1'b0) begin errors++; $display("[TB] FAIL exact_no_err actual=%0b expected=0", len_err); end
    checks++; if (pkt_cnt !== 16'd4) begin errors++; $display("[TB] FAIL exact_pkt_cnt actual=%0d expected=4", pkt_cnt); end
    for (int i = 0; i < 17; i++) begin
      s_valid = 1'b1; s_data = 8'h80 + 8'(i); s_last = (i == 16); err_clr = (i == 15);
      @(posedge clk); #1;
      if (i == 15) begin
        checks++; if (len_err !== 1'b1 || m_last !== 1'b1) begin errors++; $display("[TB] FAIL race_set_wins actual=%0b/%0b expected=1/1", len_err, m_last); end
      end
    end
    s_valid = 1'b0; s_last = 1'b0; err_clr = 1'b0;
    checks++; if (len_err !== 1'b1 || m_valid !== 1'b0) begin errors++; $display("[TB] FAIL race_after actual=%0b/%0b expected=1/0", len_err, m_valid); end
    checks++; if (pkt_cnt !== 16'd5) begin errors++; $display("[TB] FAIL race_pkt_cnt actual=%0d expected=5", pkt_cnt); end
  endtask

  task test_reset_mid_packet;
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 8'h51 + 8'(i); s_last = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    checks++; if (level !== 3'd3) begin errors++; $display("[TB] FAIL rmid_level_before actual=%0d expected=3", level); end
    #1 rst = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("[TB] FAIL rmid_flush actual=%0b/%0d expected=0/0", m_valid, level); end
    checks++; if (pkt_cnt !== 16'd0 || len_err !== 1'b0) begin errors++; $display("[TB] FAIL rmid_counters actual=%0d/%0b expected=0/0", pkt_cnt, len_err); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL rmid_s_ready actual=%0b expected=0", s_ready); end
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 8'h61; s_last = 1'b0;
    @(posedge clk); #1;
    checks++; if (m_data !== 8'h61 || m_last !== 1'b0 || m_valid !== 1'b1) begin errors++; $display("[TB] FAIL rmid_new0 actual=%0b/%h/%0b expected=1/61/0", m_valid, m_data, m_last); end
    s_data = 8'h62; s_last = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (m_data !== 8'h62 || m_last !== 1'b1 || m_valid !== 1'b1) begin errors++; $display("[TB] FAIL rmid_new1 actual=%0b/%h/%0b expected=1/62/1", m_valid, m_data, m_last); end
    checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("[TB] FAIL rmid_pkt_cnt actual=%0d expected=1", pkt_cnt); end
    @(posedge clk); #1;
  endtask

  task test_pkt_cnt_wrap;
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 8'hEE; s_last = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    checks++; if (pkt_cnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_preset actual=%h expected=ffff", pkt_cnt); end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (pkt_cnt !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_zero actual=%h expected=0000", pkt_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_exact_and_clear_race();
    test_reset_mid_packet();
    test_pkt_cnt_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dir_bus_reader.md
DIR_BUS_READER -- requirements
Module: dir_bus_reader

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-high.
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter MAX_LEN, default 16, maximum beats per packet (>=2).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 s_data  input  8  upstream beat data from the writer end.
REQ-007 s_valid  input  1  upstream beat valid.
REQ-008 s_last  input  1  upstream final beat of packet.
REQ-009 s_ready  output  1  reader can accept a beat.
REQ-010 m_data  output  8  buffered beat data.
REQ-011 m_last  output  1  buffered beat is last of packet.
REQ-012 m_valid  output  1  buffered beat available.
REQ-013 m_ready  input  1  downstream consumes the beat.
REQ-014 err_clr  input  1  clears len_err.
REQ-015 len_err  output  1  sticky: packet exceeded MAX_LEN.
REQ-016 pkt_cnt  output  16  packets delivered into the FIFO, wrapping.
REQ-017 level  output  $clog2(DEPTH+1)  current FIFO occupancy.

Function
REQ-018 SHALL implement states IDLE (no packet open), RECV (packet open), DISCARD (dropping an over-length tail).
REQ-019 Accept SHALL be s_valid & s_ready; beats SHALL never be lost or duplicated while accepted in IDLE/RECV.
REQ-020 In IDLE/RECV, s_ready SHALL be (level < DEPTH); a same-cycle pop SHALL NOT make a full FIFO ready.
REQ-021 In DISCARD, s_ready SHALL be 1 and accepted beats SHALL NOT be written.
REQ-022 SHALL track beat_cnt per packet: reset to 0 on an accepted last beat or on entering DISCARD, else +1 per accepted beat.
REQ-023 IDLE -> RECV on an accepted non-last beat; an accepted last beat in IDLE (single-beat packet) stays IDLE.
REQ-024 RECV -> IDLE on an accepted last beat with beat_cnt < MAX_LEN-1.
REQ-025 On an accepted beat with beat_cnt == MAX_LEN-1 and s_last=0: write with last forced to 1, set len_err, go DISCARD.
REQ-026 Same case with s_last=1 SHALL be a legal MAX_LEN packet: no error, go IDLE.
REQ-027 DISCARD -> IDLE on an accepted s_last beat (dropped).
REQ-028 FIFO SHALL be first-word-fall-through: written beat visible on m_data/m_last/m_valid the cycle after accept.
REQ-029 m_valid SHALL be (level != 0); pop on m_valid & m_ready; simultaneous push and pop SHALL leave level unchanged.
REQ-030 m_data/m_last SHALL remain stable while m_valid & !m_ready.
REQ-031 pkt_cnt SHALL increment once per written beat whose stored last is 1 (truncated packets included), 0xFFFF wraps to 0x0000.
REQ-032 len_err: set wins over a same-cycle err_clr; otherwise err_clr clears it next cycle.

Reset
REQ-033 While rst is high: state IDLE, pointers/level/beat_cnt/pkt_cnt 0, len_err 0, m_valid 0, s_ready 0, m_data/m_last 0.
REQ-034 Reset mid-packet SHALL discard all FIFO contents and the open packet; first beat after release starts a new packet.

Structure
REQ-035 Package dir_bus_pkg SHALL hold the state enum typedef and the beat struct typedef {last, data[7:0]}.
REQ-036 FIFO storage SHALL be the sub-module dir_bus_fifo (parameter DEPTH, push/pop/full/empty/level); the FSM, counters, and error logic stay in dir_bus_reader.

Verification
REQ-037 3-beat packet 0x11,0x22,0x33(last), m_ready=1 -> same bytes out, m_last on 0x33, one cycle latency, pkt_cnt=1.
REQ-038 m_ready=0, 6 beats offered -> s_ready drops after 4 accepted, level=4; m_ready=1 -> remaining 2 accepted, order preserved.
REQ-039 20-beat packet, MAX_LEN=16 -> 16 beats out with m_last on beat 16, beats 17-20 dropped, len_err=1, pkt_cnt+1.
REQ-040 Exactly 16-beat packet -> no len_err, all delivered; then err_clr and new overflow in same cycle -> len_err stays 1.
REQ-041 pkt_cnt preset by 65535 single-beat packets, one more -> pkt_cnt=0x0000.
REQ-042 rst asserted with level=3 mid-packet -> m_valid=0, level=0, pkt_cnt=0 immediately; next packet delivered intact.
